hier_rr_fanin: RTL and testbench
================================

Name: hier_rr_fanin

Overview:
- Parametrised N-channel packet fan-in node for the hierarchical module tree.
- Merges NUM_CH child streams into one output stream using valid/ready handshakes.
- Arbitration is round-robin. Once a packet starts, the grant is held until that packet's last beat is accepted.
- Output is registered (one beat deep) and sustains full throughput. Default NUM_CH=10 matches the ten-child fan-out of a tree level.

Parameters:
NUM_CH, 10, number of child input channels (>=2)
DATA_W, 8, data width per beat
CH_W, $clog2(NUM_CH), width of the channel-index output (derived; do not override)

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  NUM_CH  per-channel beat valid
in_data  input  NUM_CH*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W]
in_last  input  NUM_CH  per-channel end-of-packet marker
in_ready  output  NUM_CH  per-channel accept; at most one bit high in any cycle
out_valid  output  1  registered output beat valid
out_data  output  DATA_W  registered output data
out_last  output  1  registered end-of-packet marker
out_ch  output  CH_W  source channel of the current output beat
out_ready  input  1  downstream accept

Behaviour:
- Reset (async assert, sync release) sets: out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, ptr=NUM_CH-1 (channel 0 has first priority), lock_ch=0.
- in_ready is combinational and therefore 0 while rst_n=0.
- load_en = !out_valid || out_ready.
- Input transfer on channel i = in_valid[i] && in_ready[i]. Output transfer = out_valid && out_ready.

IDLE state:
- grant = first i with in_valid[i]=1, scanning ptr+1, ptr+2, ... modulo NUM_CH.
- in_ready[grant] = load_en. All other in_ready bits are 0.
- No request pending: in_ready all 0.

LOCKED state:
- in_ready[lock_ch] = load_en. All other bits are 0.
- Requests from other channels are ignored until the packet ends.

Transitions and pointer:
- IDLE, transfer with in_last=1: stay IDLE, ptr<=grant.
- IDLE, transfer with in_last=0: go to LOCKED, lock_ch<=grant.
- LOCKED, transfer with in_last=1: go to IDLE, ptr<=lock_ch.
- LOCKED, transfer with in_last=0: stay LOCKED.
- ptr changes only at end of packet, so single-beat packets rotate too.

Output register:
- On an input transfer, load out_data, out_last and out_ch from the granted channel; out_valid<=1. Latency is one cycle from input acceptance to out_valid.
- Output transfer with no input transfer in the same cycle: out_valid<=0; data fields hold their values.
- Output transfer and input transfer in the same cycle: the new beat replaces the old one. No bubble, one beat per cycle sustained.
- out_ready=0 while out_valid=1: all out_* hold stable and all in_ready are 0 (backpressure).

Boundaries:
- Pointer wrap: ptr=NUM_CH-1 scans from channel 0. The grant search covers every channel, including ptr itself, which is checked last.
- A channel deasserting in_valid mid-packet keeps the lock; the other channels wait.
- Reset mid-packet: lock is dropped, any pending output beat is discarded, ptr returns to NUM_CH-1.
- in_data and in_last on non-granted channels are don't-care.
- NUM_CH not a power of two: out_ch never exceeds NUM_CH-1.

Test Plan:
1. Reset, then in_valid=all ones, every beat last=1, out_ready=1 -> out_ch sequence 0,1,2,...,9,0,1; out_valid continuously 1 from the 2nd cycle after the first accept; no gaps.
2. ch3 sends a 4-beat packet (data 0xA0..0xA3, last on beat 4) while ch1 and ch7 request throughout -> out_data A0,A1,A2,A3 all with out_ch=3 and no interleaving; then ch7 is served, then ch1.
3. Backpressure: out_valid=1 with data 0x55, out_ready=0 for 5 cycles -> out_data=0x55 stable and in_ready=0 for all 5 cycles; when out_ready rises, the next beat loads in that same cycle.
4. Wrap: ptr=9 after serving ch9, with requests on ch0 and ch8 -> ch0 granted first, then ch8.
5. Lock with gap: ch2 beat 1 (last=0) accepted, then in_valid[2]=0 for 3 cycles while ch5 requests -> in_ready[5] stays 0; ch2 beat 2 (last=1) is accepted, then ch5 is granted.
6. Assert rst_n=0 mid-packet on ch4 -> out_valid=0 and in_ready=0 immediately (asynchronous). After release with only ch6 requesting -> ch6 is granted with no lock held.

Source files
------------

// File: rtl/hier_rr_fanin.sv
// Purpose     : N-to-1 round-robin packet fan-in; a grant is held until the packet's last beat.
// Latency     : 1 cycle from input acceptance to out_valid (single registered output beat).
// Backpressure: in_ready is all-zero while out_valid && !out_ready; otherwise one beat per cycle.
//
// Ports:
//   clk, rst_n              single rising-edge clock, asynchronous active-low reset
//   in_valid/in_data/in_last per-child beat stream, channel i data at [i*DATA_W +: DATA_W]
//   in_ready                per-child accept, at most one bit set, 0 while in reset
//   out_valid/out_data/out_last/out_ch  registered merged stream plus source channel
//   out_ready               downstream accept
module hier_rr_fanin #(
    parameter int NUM_CH = 10,
    parameter int DATA_W = 8,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CH_W-1:0]    r_ptr;
    logic [CH_W-1:0]    w_ptr_nxt;
    logic [CH_W-1:0]    r_lock_ch;
    logic [CH_W-1:0]    w_lock_nxt;

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_last;
    logic [CH_W-1:0]    r_out_ch;

    logic [DATA_W-1:0]  w_ch_data [NUM_CH];
    logic               w_load_en;
    logic               w_req_any;
    logic [CH_W-1:0]    w_grant;
    logic [CH_W-1:0]    w_scan_idx;
    logic [CH_W-1:0]    w_sel_ch;
    logic               w_sel_vld;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_sel_last;
    logic [NUM_CH-1:0]  w_ready;
    logic               w_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The output stage can take a new beat when empty or draining this cycle.
    assign w_load_en = !r_out_valid || out_ready;

    // Round-robin search starting just after r_ptr. The loop runs from the
    // farthest candidate back to the nearest so the last hit is the winner;
    // r_ptr itself is the farthest (k = NUM_CH) and so has lowest priority.
    always_comb begin : p_grant
        w_req_any  = 1'b0;
        w_grant    = '0;
        w_scan_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_scan_idx = CH_W'((int'(r_ptr) + k) % NUM_CH);
            if (in_valid[w_scan_idx]) begin
                w_req_any = 1'b1;
                w_grant   = w_scan_idx;
            end
        end
    end

    // While locked the owner keeps in_ready even if it idles mid-packet,
    // so other channels cannot slip in between beats.
    assign w_sel_ch   = (r_state == S_LOCKED) ? r_lock_ch : w_grant;
    assign w_sel_vld  = (r_state == S_LOCKED) || w_req_any;
    assign w_sel_data = w_ch_data[w_sel_ch];
    assign w_sel_last = in_last[w_sel_ch];

    // rst_n gates in_ready directly so nothing is accepted while reset is held.
    always_comb begin : p_ready
        w_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_sel_ch == CH_W'(i)) begin
                w_ready[i] = rst_n && w_sel_vld && w_load_en;
            end
        end
    end

    assign in_ready = w_ready;
    assign w_xfer   = |(w_ready & in_valid);

    // Pointer only moves at end of packet, so single-beat packets rotate too.
    always_comb begin : p_fsm_nxt
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock_ch;
        if (w_xfer) begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_last) begin
                        w_ptr_nxt = w_grant;
                    end else begin
                        w_state_nxt = S_LOCKED;
                        w_lock_nxt  = w_grant;
                    end
                end
                S_LOCKED: begin
                    if (w_sel_last) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = r_lock_ch;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_fsm_reg
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= CH_W'(NUM_CH - 1);
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_lock_ch <= w_lock_nxt;
        end
    end

    // A new beat overwrites the old one in the same cycle it drains: no bubble.
    always_ff @(posedge clk or negedge rst_n) begin : p_out_reg
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_last  <= w_sel_last;
            r_out_ch    <= w_sel_ch;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_hier_rr_fanin.sv
// Purpose     : Self-checking bench for hier_rr_fanin: directed scenarios then random traffic.
// Latency     : Inputs driven 1ns after posedge, everything sampled on the falling edge.
// Backpressure: out_ready is driven directly by the bench (held low or randomised).
module tb_hier_rr_fanin;

    localparam int NUM_CH = 10;
    localparam int DATA_W = 8;
    localparam int CH_W   = $clog2(NUM_CH);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic [NUM_CH-1:0]        in_valid = '0;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    logic [NUM_CH-1:0]        in_last = '0;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic [CH_W-1:0]          out_ch;
    logic                     out_ready = 1'b0;

    always #5 clk = ~clk;

    hier_rr_fanin #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: who owns the output (-1 = nobody), last channel that
    // finished a packet, and the contents of the one-beat output buffer.
    int          m_owner;
    int          m_ptr;
    logic        m_ovld;
    logic [7:0]  m_odata;
    logic        m_olast;
    int          m_och;

    int obs_ch[$];
    int obs_dat[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic v, input logic [7:0] d, input logic l);
        in_valid[c]               = v;
        in_data[c*DATA_W +: DATA_W] = d;
        in_last[c]                = l;
    endtask

    task automatic clear_in();
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = NUM_CH - 1;
        m_ovld  = 1'b0;
        m_odata = '0;
        m_olast = 1'b0;
        m_och   = 0;
    endtask

    // Called 1ns after a posedge. Asserts reset asynchronously, checks that
    // outputs clear immediately, then releases on a falling edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_ovld"}, 32'(out_valid), 32'd0);
        chk({tag, ".rst_rdy"}, 32'(in_ready), 32'd0);
        model_reset();
        clear_in();
        @(negedge clk);
        chk({tag, ".rst_data"}, 32'(out_data), 32'd0);
        chk({tag, ".rst_last"}, 32'(out_last), 32'd0);
        chk({tag, ".rst_ch"}, 32'(out_ch), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        obs_ch.delete();
        obs_dat.delete();
    endtask

    // One clock: check DUT against the model at the falling edge, advance the
    // model by what the rules say happens at the next rising edge.
    task automatic step(input string tag);
        int          sel;
        int          c;
        logic        load;
        logic [NUM_CH-1:0] exp_rdy;
        @(negedge clk);
        load = !m_ovld || out_ready;
        sel  = -1;
        if (m_owner >= 0) begin
            sel = m_owner;
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                c = (m_ptr + k) % NUM_CH;
                if (sel < 0 && in_valid[c]) sel = c;
            end
        end
        exp_rdy = (sel >= 0 && load) ? (NUM_CH'(1) << sel) : '0;
        chk({tag, ".rdy"}, 32'(in_ready), 32'(exp_rdy));
        chk({tag, ".ovld"}, 32'(out_valid), 32'(m_ovld));
        if (m_ovld) begin
            chk({tag, ".odata"}, 32'(out_data), 32'(m_odata));
            chk({tag, ".olast"}, 32'(out_last), 32'(m_olast));
            chk({tag, ".och"}, 32'(out_ch), 32'(m_och));
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            obs_ch.push_back(int'(out_ch));
            obs_dat.push_back(int'(out_data));
        end
        if (sel >= 0 && load && in_valid[sel]) begin
            m_ovld  = 1'b1;
            m_odata = in_data[sel*DATA_W +: DATA_W];
            m_olast = in_last[sel];
            m_och   = sel;
            if (in_last[sel]) begin
                m_owner = -1;
                m_ptr   = sel;
            end else begin
                m_owner = sel;
            end
        end else if (out_ready) begin
            m_ovld = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ch6[6];
        int exp_dat6[6];
        model_reset();
        #2;
        @(posedge clk);
        #1;

        // 1: all channels request single-beat packets, full rate.
        do_reset("t1");
        out_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b1, 8'(8'h10 + c), 1'b1);
        for (int i = 0; i < 13; i++) step("t1");
        clear_in();
        step("t1");
        chk("t1.cnt", 32'(obs_ch.size()), 32'd13);
        for (int i = 0; i < 12 && i < obs_ch.size(); i++) begin
            chk("t1.seq_ch", 32'(obs_ch[i]), 32'(i % NUM_CH));
            chk("t1.seq_dat", 32'(obs_dat[i]), 32'(8'h10 + (i % NUM_CH)));
        end

        // 2: ch3 4-beat packet, ch1/ch7 wait, then ch7 before ch1.
        do_reset("t2");
        out_ready = 1'b1;
        set_ch(3, 1'b1, 8'hA0, 1'b0);
        step("t2");
        set_ch(1, 1'b1, 8'h11, 1'b1);
        set_ch(7, 1'b1, 8'h77, 1'b1);
        set_ch(3, 1'b1, 8'hA1, 1'b0);
        step("t2");
        set_ch(3, 1'b1, 8'hA2, 1'b0);
        step("t2");
        set_ch(3, 1'b1, 8'hA3, 1'b1);
        step("t2");
        set_ch(3, 1'b0, 8'h00, 1'b0);
        step("t2");
        set_ch(7, 1'b0, 8'h00, 1'b0);
        step("t2");
        set_ch(1, 1'b0, 8'h00, 1'b0);
        step("t2");
        exp_ch6  = '{3, 3, 3, 3, 7, 1};
        exp_dat6 = '{'hA0, 'hA1, 'hA2, 'hA3, 'h77, 'h11};
        chk("t2.cnt", 32'(obs_ch.size()), 32'd6);
        for (int i = 0; i < 6 && i < obs_ch.size(); i++) begin
            chk("t2.seq_ch", 32'(obs_ch[i]), 32'(exp_ch6[i]));
            chk("t2.seq_dat", 32'(obs_dat[i]), 32'(exp_dat6[i]));
        end

        // 3: backpressure for 5 cycles holds 0x55, then reload in the same cycle.
        do_reset("t3");
        out_ready = 1'b1;
        set_ch(2, 1'b1, 8'h55, 1'b1);
        step("t3");
        set_ch(2, 1'b1, 8'h66, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("t3");
            chk("t3.hold_data", 32'(out_data), 32'h55);
            chk("t3.hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step("t3");
        chk("t3.reload", 32'(out_data), 32'h66);
        clear_in();
        step("t3");
        chk("t3.cnt", 32'(obs_dat.size()), 32'd2);
        if (obs_dat.size() == 2) begin
            chk("t3.first", 32'(obs_dat[0]), 32'h55);
            chk("t3.second", 32'(obs_dat[1]), 32'h66);
        end

        // 4: pointer wrap after serving ch9.
        do_reset("t4");
        out_ready = 1'b1;
        set_ch(9, 1'b1, 8'h99, 1'b1);
        step("t4");
        set_ch(9, 1'b0, 8'h00, 1'b0);
        set_ch(0, 1'b1, 8'hC0, 1'b1);
        set_ch(8, 1'b1, 8'hC8, 1'b1);
        step("t4");
        set_ch(0, 1'b0, 8'h00, 1'b0);
        step("t4");
        set_ch(8, 1'b0, 8'h00, 1'b0);
        step("t4");
        chk("t4.cnt", 32'(obs_ch.size()), 32'd3);
        if (obs_ch.size() == 3) begin
            chk("t4.ch_a", 32'(obs_ch[0]), 32'd9);
            chk("t4.ch_b", 32'(obs_ch[1]), 32'd0);
            chk("t4.ch_c", 32'(obs_ch[2]), 32'd8);
        end

        // 5: lock survives a 3-cycle gap on the owner.
        do_reset("t5");
        out_ready = 1'b1;
        set_ch(2, 1'b1, 8'h21, 1'b0);
        step("t5");
        set_ch(2, 1'b0, 8'h00, 1'b0);
        set_ch(5, 1'b1, 8'h50, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("t5.rdy5", 32'(in_ready[5]), 32'd0);
            step("t5");
        end
        set_ch(2, 1'b1, 8'h22, 1'b1);
        step("t5");
        set_ch(2, 1'b0, 8'h00, 1'b0);
        step("t5");
        set_ch(5, 1'b0, 8'h00, 1'b0);
        step("t5");
        chk("t5.cnt", 32'(obs_ch.size()), 32'd3);
        if (obs_ch.size() == 3) begin
            chk("t5.b1", 32'(obs_dat[0]), 32'h21);
            chk("t5.b2", 32'(obs_dat[1]), 32'h22);
            chk("t5.ch5", 32'(obs_ch[2]), 32'd5);
        end

        // 6: reset mid-packet on ch4, then ch6 alone is granted unlocked.
        do_reset("t6");
        out_ready = 1'b1;
        set_ch(4, 1'b1, 8'h40, 1'b0);
        step("t6");
        set_ch(4, 1'b1, 8'h41, 1'b0);
        step("t6");
        do_reset("t6mid");
        out_ready = 1'b1;
        set_ch(6, 1'b1, 8'h60, 1'b1);
        #3;
        chk("t6.grant6", 32'(in_ready), 32'h040);
        step("t6");
        set_ch(6, 1'b0, 8'h00, 1'b0);
        step("t6");
        chk("t6.cnt", 32'(obs_ch.size()), 32'd1);
        if (obs_ch.size() == 1) chk("t6.ch", 32'(obs_ch[0]), 32'd6);

        // Random traffic against the model.
        do_reset("rnd");
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                set_ch(c, ($urandom_range(0, 99) < 35), 8'($urandom), 1'($urandom_range(0, 1)));
            end
            out_ready = ($urandom_range(0, 99) < 70);
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
